// File: rtl/sll32_pkg.sv
// sll32_pkg -- shared definitions for the iterative 32-bit logical left shifter.
//   state_e   : controller states (IDLE, SHIFT, DONE)
//   DATA_W    : operand / result width
//   SHAMT_W   : shift amount width
//   SHAMT_LSB : position of the shamt field inside the instruction word
//   shl1()    : single-bit logical left shift with zero fill
package sll32_pkg;

  localparam int DATA_W    = 32;
  localparam int SHAMT_W   = 5;
  localparam int SHAMT_LSB = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic [DATA_W-1:0] shl1(input logic [DATA_W-1:0] v);
    return {v[DATA_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/sll32_iter.sv
// sll32_iter -- iterative logical left shift, one bit per clock.
//
// A start pulse in IDLE captures A and a 5-bit shift amount; the working
// register then shifts left once per cycle until the amount is exhausted,
// and the result is presented in the DONE cycle with a one-cycle done pulse.
// Done arrives n+1 cycles after the accepting edge for an amount n.
//
// Ports:
//   clk     in   1   rising-edge clock
//   rst_n   in   1   asynchronous active-low reset
//   start   in   1   request pulse, only honoured in IDLE
//   A       in  32   operand to shift
//   B       in  32   instruction word, shamt = B[10:6]
//   rs_amt  in   5   variable amount (only with SLL32_VAR_EN)
//   var_sel in   1   1 selects rs_amt, 0 selects shamt (only with SLL32_VAR_EN)
//   busy    out  1   high in SHIFT and DONE
//   done    out  1   one-cycle completion pulse
//   res     out 32   result, held until the next operation completes
//
// Build option: define SLL32_VAR_EN to add the rs_amt/var_sel (sllv) path.
module sll32_iter
  import sll32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
`ifdef SLL32_VAR_EN
  input  logic [4:0]  rs_amt,
  input  logic        var_sel,
`endif
  output logic        busy,
  output logic        done,
  output logic [31:0] res
);

  state_e              state_q, state_d;
  logic [SHAMT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0]   work_q, work_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [SHAMT_W-1:0]  amt;

  // Only the shamt field of the instruction word matters here.
  logic unused_b;
  assign unused_b = ^{B[31:11], B[5:0]};

`ifdef SLL32_VAR_EN
  assign amt = var_sel ? rs_amt : B[SHAMT_LSB +: SHAMT_W];
`else
  assign amt = B[SHAMT_LSB +: SHAMT_W];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d = A;
          cnt_d  = amt;
          // A zero amount skips SHIFT, so the result is loaded right away.
          if (amt == '0) begin
            state_d = DONE;
            res_d   = A;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d = shl1(work_q);
        cnt_d  = cnt_q - 5'd1;
        // Load res on the final shift so it is valid during DONE.
        if (cnt_q == 5'd1) begin
          state_d = DONE;
          res_d   = shl1(work_q);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      res_q   <= res_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign res  = res_q;

endmodule

// File: tb/tb_sll32_iter.sv
module tb_sll32_iter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] res;
`ifdef SLL32_VAR_EN
  logic [4:0]  rs_amt;
  logic        var_sel;
`endif

  int total;
  int bad;

  sll32_iter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .A       (A),
    .B       (B),
`ifdef SLL32_VAR_EN
    .rs_amt  (rs_amt),
    .var_sel (var_sel),
`endif
    .busy    (busy),
    .done    (done),
    .res     (res)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Random instruction word with the given shamt in bits [10:6].
  function automatic logic [31:0] make_b(input logic [4:0] sh);
    logic [31:0] w;
    w = $urandom;
    w = (w & ~32'h0000_07C0) | ({27'd0, sh} << 6);
    return w;
  endfunction

  // Reference: amount selection and the shift itself as plain arithmetic.
  function automatic int ref_amt(input logic [31:0] b, input logic [4:0] rs, input logic vs);
    int n;
    n = (b >> 6) & 31;
`ifdef SLL32_VAR_EN
    if (vs) n = int'(rs);
`else
    if (vs && rs == 5'd31) n = n; // variable path absent in this build
`endif
    return n;
  endfunction

  // Issue one operation from an IDLE cycle. Returns in the IDLE cycle right
  // after DONE, so a following call is back-to-back.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rs, input logic vs,
                       input logic scramble, input string tag,
                       output logic [31:0] got_res, output int got_lat);
    int          n;
    int          busy_cnt;
    logic [31:0] exp_res;
    n        = ref_amt(b, rs, vs);
    exp_res  = a << n;
    got_lat  = -1;
    got_res  = 32'h0;
    busy_cnt = 0;
    A     = a;
    B     = b;
    start = 1'b1;
`ifdef SLL32_VAR_EN
    rs_amt  = rs;
    var_sel = vs;
`endif
    @(posedge clk);
    #1;
    start = 1'b0;
    if (scramble) begin
      A = $urandom;
      B = $urandom;
    end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        got_lat = k;
        got_res = res;
        check({tag, ".busy_in_done"}, {31'd0, busy}, 32'd1);
        start = 1'b0;
        break;
      end
      if (scramble) begin
        A     = $urandom;
        B     = $urandom;
        start = 1'($urandom_range(0, 1));
      end
    end
    start = 1'b0;
    check({tag, ".latency"}, got_lat, n + 1);
    check({tag, ".res"}, got_res, exp_res);
    check({tag, ".busy_cycles"}, busy_cnt, n + 1);
    @(posedge clk);
    #1;
    check({tag, ".idle_done"}, {31'd0, done}, 32'd0);
    check({tag, ".idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, ".res_hold"}, res, exp_res);
  endtask

  initial begin
    logic [31:0] r;
    int          lat;
    int          seen_done;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    A     = 32'h0;
    B     = 32'h0;
`ifdef SLL32_VAR_EN
    rs_amt  = 5'd0;
    var_sel = 1'b0;
`endif
    #1;
    check("reset.busy", {31'd0, busy}, 32'd0);
    check("reset.done", {31'd0, done}, 32'd0);
    check("reset.res", res, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Full-range shift of a single bit.
    do_op(32'h0000_0001, make_b(5'd31), 5'd0, 1'b0, 1'b0, "sh31", r, lat);
    check("sh31.const", r, 32'h8000_0000);
    @(negedge clk);

    // Zero amount passes A through in one cycle.
    do_op(32'hDEAD_BEEF, make_b(5'd0), 5'd0, 1'b0, 1'b0, "sh0", r, lat);
    check("sh0.const", r, 32'hDEAD_BEEF);
    @(negedge clk);

    // Inputs and start toggled while shifting must not disturb the result.
    do_op(32'hF000_000F, make_b(5'd4), 5'd0, 1'b0, 1'b1, "noisy", r, lat);
    check("noisy.const", r, 32'h0000_00F0);
    check("noisy.lat", lat, 5);
    @(negedge clk);

    // Reset in the middle of a shift: no done, outputs cleared immediately.
    A     = 32'h1234_5678;
    B     = make_b(5'd8);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.busy", {31'd0, busy}, 32'd0);
    check("midrst.done", {31'd0, done}, 32'd0);
    check("midrst.res", res, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("midrst.no_done", seen_done, 0);
    do_op(32'h0000_0001, make_b(5'd1), 5'd0, 1'b0, 1'b0, "postrst", r, lat);
    check("postrst.const", r, 32'h0000_0002);
    check("postrst.lat", lat, 2);
    @(negedge clk);

    // Back-to-back: second start in the IDLE cycle right after DONE.
    do_op(32'h0000_0003, make_b(5'd2), 5'd0, 1'b0, 1'b0, "b2b_a", r, lat);
    check("b2b_a.const", r, 32'h0000_000C);
    do_op(32'h0000_0001, make_b(5'd3), 5'd0, 1'b0, 1'b0, "b2b_b", r, lat);
    check("b2b_b.const", r, 32'h0000_0008);
    check("b2b_b.lat", lat, 4);
    @(negedge clk);

`ifdef SLL32_VAR_EN
    do_op(32'h0000_0001, make_b(5'd2), 5'd5, 1'b1, 1'b0, "var1", r, lat);
    check("var1.const", r, 32'h0000_0020);
    check("var1.lat", lat, 6);
    do_op(32'h0000_0001, make_b(5'd2), 5'd5, 1'b0, 1'b0, "var0", r, lat);
    check("var0.const", r, 32'h0000_0004);
    check("var0.lat", lat, 3);
    @(negedge clk);
`endif

    // Randomized operations with random gaps and optional input noise.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra;
      logic [4:0]  rsh;
      logic [4:0]  rrs;
      logic        rvs;
      logic        rsc;
      int          gap;
      ra  = $urandom;
      rsh = 5'($urandom_range(0, 31));
      rrs = 5'($urandom_range(0, 31));
      rvs = 1'($urandom_range(0, 1));
      rsc = 1'($urandom_range(0, 1));
      gap = $urandom_range(0, 2);
      do_op(ra, make_b(rsh), rrs, rvs, rsc, "rand", r, lat);
      repeat (gap) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
